// File: rtl/dbg_pkg.sv
// Shared definitions for the core debug halt controller.
// Holds the dcsr.cause encodings and the controller state encoding.
package dbg_pkg;

    // dcsr.cause values reported on halt_cause
    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0] CAUSE_TRIG    = 3'd2;
    localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0] CAUSE_STEP    = 3'd4;
    localparam logic [2:0] CAUSE_RSTHALT = 3'd5;

    typedef enum logic [1:0] {
        ST_POR_CHK = 2'd0,
        ST_RUN     = 2'd1,
        ST_STEP    = 2'd2,
        ST_HALTED  = 2'd3
    } dbg_state_e;

endpackage

// File: rtl/dbg_halt_ctrl_if.sv
// Debug-module / core-pipeline signal bundle for dbg_halt_ctrl.
//   master : the dm + pipeline side (drives requests, retire info, trigger hits)
//   slave  : the halt controller (drives dbg_mode, cause, handshake pulses)
interface dbg_halt_ctrl_if #(
    parameter int NUM_TRIG   = 4,
    parameter int STEP_CNT_W = 8,
    parameter int TRIG_IDX_W = 2
);
    logic                  haltreq;
    logic                  resethaltreq;
    logic                  resumereq_w1;
    logic                  step;
    logic [STEP_CNT_W-1:0] step_num;
    logic                  ebreak;
    logic                  ebreak_en;
    logic [NUM_TRIG-1:0]   trig_hit;
    logic                  dret;
    logic                  instr_retire;
    logic                  dbg_mode;
    logic [2:0]            halt_cause;
    logic [TRIG_IDX_W-1:0] trig_idx;
    logic                  halted_pulse;
    logic                  resumeack;
    logic                  stepping;

    modport master (
        output haltreq, resethaltreq, resumereq_w1, step, step_num, ebreak,
               ebreak_en, trig_hit, dret, instr_retire,
        input  dbg_mode, halt_cause, trig_idx, halted_pulse, resumeack, stepping
    );

    modport slave (
        input  haltreq, resethaltreq, resumereq_w1, step, step_num, ebreak,
               ebreak_en, trig_hit, dret, instr_retire,
        output dbg_mode, halt_cause, trig_idx, halted_pulse, resumeack, stepping
    );
endinterface

// File: rtl/dbg_trig_prio_enc.sv
// Lowest-index priority encoder over the trigger hit vector.
//   hit     : per-trigger hit bits
//   any_hit : at least one bit of hit is set
//   idx     : index of the lowest set bit (0 when none set)
module dbg_trig_prio_enc #(
    parameter int NUM_TRIG   = 4,
    parameter int TRIG_IDX_W = 2
) (
    input  logic [NUM_TRIG-1:0]   hit,
    output logic                  any_hit,
    output logic [TRIG_IDX_W-1:0] idx
);
    always_comb begin
        any_hit = |hit;
        idx     = '0;
        // Walk from the top down so the lowest set bit is the last writer.
        for (int i = NUM_TRIG - 1; i >= 0; i--) begin
            if (hit[i]) idx = TRIG_IDX_W'(i);
        end
    end
endmodule

// File: rtl/dbg_halt_ctrl.sv
// Core debug-mode controller: breakpoints, N-instruction stepping, debugger
// halt requests and reset-halt, plus the halt/resume handshake with the dm.
//   cpu_clk, cpu_rst : core clock, synchronous active-high reset
//   bus (slave)      : dm/pipeline inputs; dbg_mode, halt_cause, trig_idx,
//                      halted_pulse (dpc capture strobe), resumeack, stepping
module dbg_halt_ctrl
    import dbg_pkg::*;
#(
    parameter int NUM_TRIG   = 4,
    parameter int STEP_CNT_W = 8,
    parameter int TRIG_IDX_W = 2
) (
    input  logic           cpu_clk,
    input  logic           cpu_rst,
    dbg_halt_ctrl_if.slave bus
);
    dbg_state_e            state_q, state_d, cur_state;
    logic                  rst_q;
    logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
    logic                  dbg_mode_q, dbg_mode_d;
    logic [2:0]            cause_q, cause_d;
    logic [TRIG_IDX_W-1:0] idx_q, idx_d;
    logic                  pulse_q, pulse_d;
    logic                  ack_q, ack_d;
    logic                  stepping_q, stepping_d;

    logic                  any_hit;
    logic [TRIG_IDX_W-1:0] hit_idx;
    logic                  halt_go;
    logic [2:0]            halt_sel;

    dbg_trig_prio_enc #(
        .NUM_TRIG   (NUM_TRIG),
        .TRIG_IDX_W (TRIG_IDX_W)
    ) u_prio (
        .hit     (bus.trig_hit),
        .any_hit (any_hit),
        .idx     (hit_idx)
    );

    // The state register holds RUN through reset; the cycle right after
    // reset drops is recognised through rst_q and acts as POR_CHK.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q    <= ST_RUN;
            rst_q      <= 1'b1;
            cnt_q      <= '0;
            dbg_mode_q <= 1'b0;
            cause_q    <= CAUSE_NONE;
            idx_q      <= '0;
            pulse_q    <= 1'b0;
            ack_q      <= 1'b0;
            stepping_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_q      <= 1'b0;
            cnt_q      <= cnt_d;
            dbg_mode_q <= dbg_mode_d;
            cause_q    <= cause_d;
            idx_q      <= idx_d;
            pulse_q    <= pulse_d;
            ack_q      <= ack_d;
            stepping_q <= stepping_d;
        end
    end

    always_comb begin
        cur_state  = rst_q ? ST_POR_CHK : state_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        dbg_mode_d = dbg_mode_q;
        cause_d    = cause_q;
        idx_d      = idx_q;
        pulse_d    = 1'b0;
        ack_d      = 1'b0;
        stepping_d = stepping_q;
        halt_go    = 1'b0;
        halt_sel   = CAUSE_NONE;

        case (cur_state)
            ST_POR_CHK: begin
                if (bus.resethaltreq) begin
                    state_d    = ST_HALTED;
                    dbg_mode_d = 1'b1;
                    pulse_d    = 1'b1;
                    cause_d    = CAUSE_RSTHALT;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_STEP: begin
                if (any_hit) begin
                    halt_go  = 1'b1;
                    halt_sel = CAUSE_TRIG;
                end else if (bus.ebreak && bus.ebreak_en) begin
                    halt_go  = 1'b1;
                    halt_sel = CAUSE_EBREAK;
                end else if (bus.haltreq) begin
                    halt_go  = 1'b1;
                    halt_sel = CAUSE_HALTREQ;
                end else if (cur_state == ST_STEP && bus.instr_retire &&
                             cnt_q == STEP_CNT_W'(1)) begin
                    halt_go  = 1'b1;
                    halt_sel = CAUSE_STEP;
                end

                // Counter saturates at zero; a retire with nothing left is ignored.
                if (cur_state == ST_STEP && bus.instr_retire && cnt_q != '0)
                    cnt_d = cnt_q - STEP_CNT_W'(1);

                if (halt_go) begin
                    state_d    = ST_HALTED;
                    dbg_mode_d = 1'b1;
                    pulse_d    = 1'b1;
                    stepping_d = 1'b0;
                    cnt_d      = '0;
                    cause_d    = halt_sel;
                    if (halt_sel == CAUSE_TRIG) idx_d = hit_idx;
                end
            end

            ST_HALTED: begin
                // resume and dret collapse into one exit and one ack
                if (bus.resumereq_w1 || bus.dret) begin
                    ack_d      = 1'b1;
                    dbg_mode_d = 1'b0;
                    if (bus.step) begin
                        cnt_d      = (bus.step_num == '0) ? STEP_CNT_W'(1) : bus.step_num;
                        state_d    = ST_STEP;
                        stepping_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: state_d = ST_RUN;
        endcase
    end

    assign bus.dbg_mode     = dbg_mode_q;
    assign bus.halt_cause   = cause_q;
    assign bus.trig_idx     = idx_q;
    assign bus.halted_pulse = pulse_q;
    assign bus.resumeack    = ack_q;
    assign bus.stepping     = stepping_q;
endmodule

// File: doc/dbg_halt_ctrl.md
Name: dbg_halt_ctrl

Overview:
Core debug-mode controller for the next-generation debug subsystem. It supports multi-trigger breakpoints, N-instruction stepping, debugger halt requests and reset-halt. It records the halt cause and the index of the trigger that fired, and runs the halt/resume handshake with the debug module. It sits between the debug module (dm) and the core pipeline and drives the dbg_mode seen by the fetch/CSR logic.

Parameters:
NUM_TRIG, 4, number of hardware trigger (breakpoint) inputs, range 1..16
STEP_CNT_W, 8, width of the step-count field; up to 2^STEP_CNT_W-1 instructions per step
TRIG_IDX_W, 2, width of trig_idx; must equal clog2(NUM_TRIG), minimum 1

Ports:
cpu_clk  in  1  core clock
cpu_rst  in  1  synchronous, active-high reset
haltreq  in  1  debugger halt request (level)
resethaltreq  in  1  halt-on-reset request; sampled only in the first cycle after reset deasserts
resumereq_w1  in  1  one-cycle resume pulse from dm
step  in  1  dcsr.step
step_num  in  STEP_CNT_W  instructions to execute per step; 0 is treated as 1
ebreak  in  1  ebreak retired
ebreak_en  in  1  dcsr.ebreakm; when 0, ebreak does not enter debug mode
trig_hit  in  NUM_TRIG  per-trigger hit vector, valid in the cycle of the hit
dret  in  1  dret retired
instr_retire  in  1  one instruction retired this cycle
dbg_mode  out  1  core is in debug mode
halt_cause  out  3  dcsr.cause: 1 ebreak, 2 trigger, 3 haltreq, 4 step, 5 resethaltreq
trig_idx  out  TRIG_IDX_W  lowest-index trigger that caused the last trigger halt
halted_pulse  out  1  one-cycle pulse on entry to HALTED; used as the dpc capture strobe
resumeack  out  1  one-cycle acknowledge on leaving HALTED
stepping  out  1  a step sequence is active

Behaviour:
- Reset values: dbg_mode=0, halt_cause=0, trig_idx=0, halted_pulse=0, resumeack=0, stepping=0, state=RUN, step counter=0.
- The first cycle after cpu_rst falls is POR_CHK. If resethaltreq=1, go to HALTED with cause 5. Otherwise go to RUN.
- States: POR_CHK, RUN, STEP, HALTED.
- Halt events are evaluated in RUN and STEP. Priority, highest first:
  - trigger: any trig_hit bit set
  - ebreak: ebreak && ebreak_en
  - haltreq
  - step completion
- On a halt event: at the next clock edge, state=HALTED, dbg_mode=1, halted_pulse=1 for exactly one cycle, and halt_cause updates. trig_idx updates only for cause 2. The latency is 1 cycle.
- HALTED, on resumereq_w1:
  - resumeack=1 for one cycle and dbg_mode=0 at the next edge.
  - If step=1: load counter = (step_num==0 ? 1 : step_num), go to STEP, stepping=1.
  - Otherwise go to RUN.
- HALTED, on dret: same exit as resumereq_w1. If both are asserted in the same cycle, there is a single exit and a single resumeack.
- While HALTED, haltreq, ebreak and trig_hit are ignored. halt_cause and trig_idx hold.
- STEP:
  - Each instr_retire decrements the counter.
  - When instr_retire arrives with counter==1: halt with cause 4 at the next edge and set stepping=0.
  - If an ebreak, trigger or haltreq occurs in the same cycle as that final retire, it wins by priority, step is abandoned and stepping=0.
  - The counter never underflows. instr_retire with counter==0 is ignored.
- RUN with haltreq held high: halts at the next edge. After resume, if haltreq is still high, the block re-halts one cycle after resumeack, because the next RUN cycle re-evaluates.
- cpu_rst asserted at any time: all state returns to reset values at the next edge. A step in progress is abandoned.

Decomposition:
- Shared package dbg_pkg holds:
  - the cause encodings CAUSE_EBREAK=3'd1, CAUSE_TRIG=3'd2, CAUSE_HALTREQ=3'd3, CAUSE_STEP=3'd4, CAUSE_RSTHALT=3'd5
  - the state encoding for POR_CHK/RUN/STEP/HALTED
- One sub-module, dbg_trig_prio_enc: a parametrised lowest-index priority encoder over trig_hit that outputs any_hit and idx.
- The FSM, step counter and output registers stay in dbg_halt_ctrl.

Test Plan:
1. Reset halt: resethaltreq=1, release cpu_rst → cycle 1 after release: dbg_mode=1, halt_cause=5, one halted_pulse. Then pulse resumereq_w1 → resumeack=1 and dbg_mode=0 next cycle.
2. Multi-step: in HALTED, step=1 with step_num=3, pulse resume, then retire 3 instructions on non-consecutive cycles → halt on the edge after the 3rd retire with cause=4. With step_num=0, halt after the 1st retire.
3. Trigger priority: in RUN, trig_hit=4'b1010 and ebreak=1, ebreak_en=1 in the same cycle → cause=2, trig_idx=1.
4. ebreak gating: ebreak with ebreak_en=0 → no halt. ebreak with ebreak_en=1 → cause=1 with 1-cycle latency.
5. Step preempted: step_num=2; on the 2nd retire assert haltreq in the same cycle → cause=3, stepping=0. Also: dret and resumereq_w1 in the same cycle → exactly one resumeack.
6. Reset mid-step: step_num=5, after 2 retires assert cpu_rst for 1 cycle → all outputs at reset values, state=RUN after POR_CHK, no stale step halt on later retires.
